// File: rtl/definitions.sv
// Shared types for the sequential ALU: opcodes, controller states and the
// operating mode of the shared shift/multiply iterator.
package definitions;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    SUB   = 4'd1,
    AND   = 4'd2,
    OR    = 4'd3,
    XOR   = 4'd4,
    PASSB = 4'd5,
    CMP   = 4'd6,
    SHLN  = 4'd7,
    SHRN  = 4'd8,
    MUL   = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // What the iterator does on each step; chosen once at load time.
  typedef enum logic [1:0] {
    CORE_MUL = 2'd0,
    CORE_SHL = 2'd1,
    CORE_SHR = 2'd2
  } core_mode_t;

endpackage

// File: rtl/seq_alu_mul_core.sv
// Shift-add iterator shared by MUL and the one-bit-per-cycle shifts.
// Holds the working word (hi:lo), the multiplicand and a step counter.
// The *_nxt outputs show what the next step will produce so the controller
// can capture the final value on the same edge the last step happens.
module seq_alu_mul_core
  import definitions::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic             step,
  input  core_mode_t       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CNT_W-1:0] cnt_init,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt,
  output logic             out_nxt,
  output logic             last
);

  core_mode_t       mode_q, mode_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_sum;

  // Conditional add of the multiplicand into the high word (one partial product).
  assign acc_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

  // The step that will happen next counts down from cnt_init; this is the final one.
  assign last = (cnt_q == CNT_W'(1));

  // One iteration of the selected mode, plus load/step bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    hi_nxt  = hi_q;
    lo_nxt  = lo_q;
    out_nxt = 1'b0;
    mode_d  = mode_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;

    case (mode_q)
      CORE_MUL: begin
        hi_nxt = acc_sum[WIDTH:1];
        lo_nxt = {acc_sum[0], lo_q[WIDTH-1:1]};
      end
      CORE_SHL: begin
        lo_nxt  = {lo_q[WIDTH-2:0], 1'b0};
        out_nxt = lo_q[WIDTH-1];
      end
      CORE_SHR: begin
        lo_nxt  = {1'b0, lo_q[WIDTH-1:1]};
        out_nxt = lo_q[0];
      end
      default: ;
    endcase

    if (load) begin
      mode_d  = mode;
      mcand_d = a;
      hi_d    = '0;
      lo_d    = (mode == CORE_MUL) ? b : a;
      cnt_d   = cnt_init;
    end else if (step) begin
      hi_d  = hi_nxt;
      lo_d  = lo_nxt;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Iterator state register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      // NOTE: only a handful of flops, so the datapath is reset too; nothing here is RAM.
      mode_q  <= CORE_MUL;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      mode_q  <= mode_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with persistent C/Z/N flags and a start/ready/done handshake.
// Single-cycle ops are computed inline; SHLN/SHRN/MUL run on the shared iterator.
module seq_alu
  import definitions::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_carry,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             c_flag,
  output logic             z_flag,
  output logic             n_flag
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] WIDTH_B  = WIDTH'(WIDTH);

  alu_state_t       state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             mul_q, mul_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             zn_from_res;

  logic [CNT_W-1:0] shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;

  logic             core_load;
  logic             core_step;
  core_mode_t       core_mode;
  logic [CNT_W-1:0] core_cnt;
  logic [WIDTH-1:0] core_hi_nxt;
  logic [WIDTH-1:0] core_lo_nxt;
  logic             core_out_nxt;
  logic             core_last;

  // Shifting further than the word width behaves like shifting exactly WIDTH.
  assign shamt    = (b >= WIDTH_B) ? CNT_FULL : CNT_W'(b);
  assign add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, use_carry & c_q};
  assign sub_full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, use_carry & ~c_q};

  seq_alu_mul_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .CLK      (CLK),
    .Reset    (Reset),
    .load     (core_load),
    .step     (core_step),
    .mode     (core_mode),
    .a        (a),
    .b        (b),
    .cnt_init (core_cnt),
    .hi_nxt   (core_hi_nxt),
    .lo_nxt   (core_lo_nxt),
    .out_nxt  (core_out_nxt),
    .last     (core_last)
  );

  // Controller next state and next register outputs.
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    done_d      = done_q;
    mul_d       = mul_q;
    result_d    = result_q;
    hi_d        = hi_q;
    c_d         = c_q;
    z_d         = z_q;
    n_d         = n_q;
    zn_from_res = 1'b0;
    core_load   = 1'b0;
    core_step   = 1'b0;
    core_mode   = CORE_MUL;
    core_cnt    = CNT_FULL;

    case (state_q)
      IDLE: begin
        if (start) begin
          ready_d = 1'b0;
          state_d = DONE;
          done_d  = 1'b1;
          case (op)
            ADD: begin
              result_d    = add_full[WIDTH-1:0];
              c_d         = add_full[WIDTH];
              hi_d        = '0;
              zn_from_res = 1'b1;
            end
            SUB: begin
              result_d    = sub_full[WIDTH-1:0];
              c_d         = ~sub_full[WIDTH];
              hi_d        = '0;
              zn_from_res = 1'b1;
            end
            CMP: begin
              c_d = ~sub_full[WIDTH];
              z_d = ~|sub_full[WIDTH-1:0];
              n_d = sub_full[WIDTH-1];
            end
            AND: begin
              result_d    = a & b;
              hi_d        = '0;
              zn_from_res = 1'b1;
            end
            OR: begin
              result_d    = a | b;
              hi_d        = '0;
              zn_from_res = 1'b1;
            end
            XOR: begin
              result_d    = a ^ b;
              hi_d        = '0;
              zn_from_res = 1'b1;
            end
            PASSB: begin
              result_d    = b;
              hi_d        = '0;
              zn_from_res = 1'b1;
            end
            SHLN, SHRN: begin
              if (shamt == '0) begin
                result_d    = a;
                hi_d        = '0;
                zn_from_res = 1'b1;
              end else begin
                state_d   = RUN;
                done_d    = 1'b0;
                mul_d     = 1'b0;
                core_load = 1'b1;
                core_mode = (op == SHLN) ? CORE_SHL : CORE_SHR;
                core_cnt  = shamt;
              end
            end
            MUL: begin
              state_d   = RUN;
              done_d    = 1'b0;
              mul_d     = 1'b1;
              core_load = 1'b1;
              core_mode = CORE_MUL;
              core_cnt  = CNT_FULL;
            end
            default: begin
              result_d    = '0;
              hi_d        = '0;
              zn_from_res = 1'b1;
            end
          endcase
        end
      end

      RUN: begin
        core_step = 1'b1;
        if (core_last) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = core_lo_nxt;
          if (mul_q) begin
            hi_d = core_hi_nxt;
            c_d  = 1'b0;
            z_d  = ~|{core_hi_nxt, core_lo_nxt};
            n_d  = core_hi_nxt[WIDTH-1];
          end else begin
            hi_d        = '0;
            c_d         = core_out_nxt;
            zn_from_res = 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
        ready_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase

    if (zn_from_res) begin
      z_d = ~|result_d;
      n_d = result_d[WIDTH-1];
    end
  end

  // Controller state, handshake and architectural result/flag registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      mul_q    <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      mul_q    <= mul_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = hi_q;
  assign c_flag    = c_q;
  assign z_flag    = z_q;
  assign n_flag    = n_q;

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=8): each accepted op pushes its expected outcome
// to a scoreboard; the entry is popped and compared when done pulses.
module tb_seq_alu;
  import definitions::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       use_carry;
  logic       ready;
  logic       done;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic       c_flag;
  logic       z_flag;
  logic       n_flag;

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       n;
    int         lat;
  } exp_t;

  exp_t       sb_q[$];
  int         total = 0;
  int         bad   = 0;
  int         last_lat;
  logic [7:0] m_res;
  logic [7:0] m_hi;
  logic       m_c;
  logic       m_z;
  logic       m_n;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut (
    .CLK       (clk),
    .Reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .use_carry (use_carry),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .n_flag    (n_flag)
  );

  task automatic model_clear();
    m_res = 8'h00; m_hi = 8'h00; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
    sb_q.delete();
  endtask

  // Reference behaviour of one instruction; updates the architectural model.
  task automatic model_push(input logic [3:0] o, input logic [7:0] ma, input logic [7:0] mb,
                            input logic mu);
    exp_t        e;
    logic [8:0]  t;
    logic [15:0] p;
    int          n;
    t = '0;
    p = '0;
    e.res = m_res; e.hi = m_hi; e.c = m_c; e.z = m_z; e.n = m_n; e.lat = 1;
    n = (mb > 8) ? 8 : int'(mb);
    case (o)
      ADD: begin
        t = {1'b0, ma} + {1'b0, mb} + {8'd0, mu & m_c};
        e.res = t[7:0]; e.hi = 8'h00; e.c = t[8];
      end
      SUB, CMP: begin
        t = {1'b0, ma} - {1'b0, mb} - {8'd0, mu & ~m_c};
        e.c = ~t[8];
        if (o == SUB) begin e.res = t[7:0]; e.hi = 8'h00; end
      end
      AND:   begin e.res = ma & mb; e.hi = 8'h00; end
      OR:    begin e.res = ma | mb; e.hi = 8'h00; end
      XOR:   begin e.res = ma ^ mb; e.hi = 8'h00; end
      PASSB: begin e.res = mb;      e.hi = 8'h00; end
      SHLN: begin
        p = {8'd0, ma} << n;
        e.res = p[7:0]; e.hi = 8'h00; e.lat = n + 1;
        if (n != 0) e.c = p[8];
      end
      SHRN: begin
        p = {ma, 8'd0} >> n;
        e.res = p[15:8]; e.hi = 8'h00; e.lat = n + 1;
        if (n != 0) e.c = p[7];
      end
      MUL: begin
        p = ma * mb;
        e.res = p[7:0]; e.hi = p[15:8]; e.c = 1'b0; e.lat = 9;
      end
      default: begin e.res = 8'h00; e.hi = 8'h00; end
    endcase
    if (o == CMP) begin
      e.z = (t[7:0] == 8'h00); e.n = t[7];
    end else if (o == MUL) begin
      e.z = (p == 16'h0000); e.n = p[15];
    end else begin
      e.z = (e.res == 8'h00); e.n = e.res[7];
    end
    m_res = e.res; m_hi = e.hi; m_c = e.c; m_z = e.z; m_n = e.n;
    sb_q.push_back(e);
  endtask

  // Called just after a negedge while the DUT is idle; returns #1 after the accept edge.
  task automatic issue(input logic [3:0] o, input logic [7:0] ia, input logic [7:0] ib,
                       input logic iu);
    model_push(o, ia, ib, iu);
    op = o; a = ia; b = ib; use_carry = iu; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 4'($urandom); a = 8'($urandom); b = 8'($urandom); use_carry = 1'($urandom);
  endtask

  // Wait for done (bounded), compare against the scoreboard, then check the pulse ends.
  task automatic finish_op(input string name, input bit jam);
    exp_t e;
    int   lat;
    bit   got;
    if (sb_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty", name);
      return;
    end
    e   = sb_q.pop_front();
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      total++;
      if (ready !== 1'b0) begin
        bad++; $display("FAIL %s ready_busy cyc=%0d got=%b want=0", name, lat, ready);
      end
      if (done === 1'b1) got = 1'b1;
      else if (jam) begin
        start = 1'b1; op = ADD; a = 8'($urandom); b = 8'($urandom);
      end
    end
    start    = 1'b0;
    last_lat = lat;
    if (!got) begin
      total++; bad++;
      $display("FAIL %s timeout waiting for done after %0d cycles", name, lat);
      return;
    end
    total++;
    if (lat !== e.lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, e.lat); end
    total++;
    if (result !== e.res) begin bad++; $display("FAIL %s result got=%h want=%h", name, result, e.res); end
    total++;
    if (result_hi !== e.hi) begin bad++; $display("FAIL %s result_hi got=%h want=%h", name, result_hi, e.hi); end
    total++;
    if ({c_flag, z_flag, n_flag} !== {e.c, e.z, e.n}) begin
      bad++; $display("FAIL %s czn got=%b%b%b want=%b%b%b", name, c_flag, z_flag, n_flag, e.c, e.z, e.n);
    end
    @(negedge clk);
    total++;
    if ({done, ready} !== 2'b01) begin
      bad++; $display("FAIL %s after_done done,ready got=%b%b want=01", name, done, ready);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] o, input logic [7:0] ia,
                        input logic [7:0] ib, input logic iu);
    issue(o, ia, ib, iu);
    finish_op(name, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = ADD; a = 8'h00; b = 8'h00; use_carry = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({ready, done, result, result_hi, c_flag, z_flag, n_flag} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      bad++;
      $display("FAIL reset rdy=%b done=%b res=%h hi=%h czn=%b%b%b want 1 0 00 00 000",
               ready, done, result, result_hi, c_flag, z_flag, n_flag);
    end
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_add_carry();
    run_op("add_ff_01", ADD, 8'hFF, 8'h01, 1'b0);
    total++;
    if ({result, c_flag, z_flag, n_flag} !== {8'h00, 3'b110}) begin
      bad++; $display("FAIL add_ff_01 res,czn got=%h,%b%b%b want=00,110", result, c_flag, z_flag, n_flag);
    end
    run_op("add_chain", ADD, 8'h00, 8'h00, 1'b1);
    total++;
    if ({result, c_flag, z_flag} !== {8'h01, 2'b00}) begin
      bad++; $display("FAIL add_chain res,cz got=%h,%b%b want=01,00", result, c_flag, z_flag);
    end
  endtask

  task automatic test_sub_cmp();
    run_op("sub_05_07", SUB, 8'h05, 8'h07, 1'b0);
    total++;
    if ({result, c_flag, n_flag} !== {8'hFE, 2'b01}) begin
      bad++; $display("FAIL sub_05_07 res,cn got=%h,%b%b want=FE,01", result, c_flag, n_flag);
    end
    run_op("cmp_07_07", CMP, 8'h07, 8'h07, 1'b0);
    total++;
    if ({result, c_flag, z_flag} !== {8'hFE, 2'b11}) begin
      bad++; $display("FAIL cmp_07_07 res,cz got=%h,%b%b want=FE,11", result, c_flag, z_flag);
    end
  endtask

  task automatic test_shift();
    run_op("shln_b3_3", SHLN, 8'hB3, 8'h03, 1'b0);
    total++;
    if ({last_lat[3:0], result, c_flag} !== {4'd4, 8'h98, 1'b1}) begin
      bad++; $display("FAIL shln_b3_3 lat,res,c got=%0d,%h,%b want=4,98,1", last_lat, result, c_flag);
    end
    run_op("shrn_b3_9", SHRN, 8'hB3, 8'h09, 1'b0);
    total++;
    if ({last_lat[3:0], result, c_flag} !== {4'd9, 8'h00, 1'b1}) begin
      bad++; $display("FAIL shrn_b3_9 lat,res,c got=%0d,%h,%b want=9,00,1", last_lat, result, c_flag);
    end
    run_op("shln_zero", SHLN, 8'h5A, 8'h00, 1'b0);
    run_op("shrn_81_1", SHRN, 8'h81, 8'h01, 1'b0);
    run_op("shln_01_8", SHLN, 8'h01, 8'h08, 1'b0);
  endtask

  task automatic test_mul();
    issue(MUL, 8'h0F, 8'h11, 1'b0);
    finish_op("mul_0f_11_jam", 1'b1);
    total++;
    if ({last_lat[3:0], result_hi, result, z_flag, n_flag} !== {4'd9, 16'h00FF, 2'b00}) begin
      bad++; $display("FAIL mul_0f_11 lat,prod,zn got=%0d,%h%h,%b%b want=9,00FF,00",
                      last_lat, result_hi, result, z_flag, n_flag);
    end
    run_op("mul_ff_ff", MUL, 8'hFF, 8'hFF, 1'b0);
    total++;
    if ({result_hi, result, n_flag} !== {16'hFE01, 1'b1}) begin
      bad++; $display("FAIL mul_ff_ff prod,n got=%h%h,%b want=FE01,1", result_hi, result, n_flag);
    end
    run_op("mul_zero", MUL, 8'h00, 8'h37, 1'b0);
  endtask

  task automatic test_logic_undef();
    run_op("and",     AND,   8'hF0, 8'h3C, 1'b0);
    run_op("or",      OR,    8'h80, 8'h01, 1'b0);
    run_op("xor",     XOR,   8'hAA, 8'hAA, 1'b0);
    run_op("passb",   PASSB, 8'h12, 8'h9C, 1'b0);
    run_op("undef_b", 4'hB,  8'h12, 8'h34, 1'b0);
    total++;
    if ({result, z_flag, n_flag} !== {8'h00, 2'b10}) begin
      bad++; $display("FAIL undef_b res,zn got=%h,%b%b want=00,10", result, z_flag, n_flag);
    end
    run_op("undef_f", 4'hF,  8'hFF, 8'hFF, 1'b1);
  endtask

  task automatic test_reset_mid_op();
    bit saw_done;
    run_op("mul_pre", MUL, 8'hFF, 8'hFF, 1'b0);
    issue(MUL, 8'h0F, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({ready, done, result, result_hi, c_flag, z_flag, n_flag} !== {1'b1, 1'b0, 16'h0000, 3'b000}) begin
      bad++;
      $display("FAIL reset_mid rdy=%b done=%b res=%h hi=%h czn=%b%b%b want 1 0 00 00 000",
               ready, done, result, result_hi, c_flag, z_flag, n_flag);
    end
    reset = 1'b0;
    model_clear();
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin bad++; $display("FAIL reset_mid aborted op still pulsed done got=1 want=0"); end
    run_op("add_after_reset", ADD, 8'h12, 8'h34, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] o;
    logic [7:0] ra;
    logic [7:0] rb;
    for (int i = 0; i < 16; i++) begin
      o  = 4'($urandom_range(15));
      ra = 8'($urandom);
      rb = ($urandom_range(1) == 1) ? 8'($urandom_range(9)) : 8'($urandom);
      run_op($sformatf("b2b_%0d_op%0d", i, o), o, ra, rb, 1'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_carry();
    test_sub_cmp();
    test_shift();
    test_mul();
    test_logic_undef();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
